// File: rtl/posit_encode_pipe.sv
// Two-stage posit encoder: builds regime/exponent/fraction into a body with guard
// and sticky bits, then rounds to nearest-even, saturates and applies the sign.
module posit_encode_pipe #(
   parameter int n          = 16,
   parameter int es         = 1,
   parameter int FRAC_WIDTH = 16,
   parameter int LZC_WIDTH  = $clog2(n-1),
   parameter int EXP_WIDTH  = LZC_WIDTH+1+es
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic                        sign_i,
   input  logic                        zero_i,
   input  logic                        nar_i,
   input  logic signed [EXP_WIDTH:0]   exp_i,
   input  logic [FRAC_WIDTH-1:0]       frac_i,
   input  logic                        sticky_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [n-1:0]                posit_o
);

   localparam int SW = n + FRAC_WIDTH + es + 2;
   localparam int BW = n - 1;
   localparam logic signed [EXP_WIDTH:0] K_HI  = (EXP_WIDTH+1)'(n-2);
   localparam logic signed [EXP_WIDTH:0] K_LO  = (EXP_WIDTH+1)'(-(n-2));
   localparam logic [EXP_WIDTH:0]        EMASK = (EXP_WIDTH+1)'((1 << es) - 1);

   logic s1_valid, s2_valid, s1_adv;
   logic [BW-1:0] s1_body;
   logic s1_guard, s1_sticky, s1_sign, s1_zero, s1_nar, s1_maxpos, s1_minpos;

   assign s1_adv      = !s2_valid | out_ready_i;
   assign in_ready_o  = !s1_valid | s1_adv;
   assign out_valid_o = s2_valid;

   // ---------------- stage 1: regime build ----------------
   logic signed [EXP_WIDTH:0] k_full;
   logic signed [LZC_WIDTH:0] k_c;
   logic [EXP_WIDTH:0]        exp_u;
   logic [LZC_WIDTH-1:0]      shamt;
   logic                      k_max, k_min;
   logic [SW-1:0]             x, sh;
   logic [BW-1:0]             d_body;
   logic                      d_guard, d_sticky;

   always_comb begin
      k_full = exp_i >>> es;
      exp_u  = exp_i;
      k_max  = k_full > K_HI;
      k_min  = k_full < K_LO;
      k_c    = k_max ? K_HI[LZC_WIDTH:0] : k_min ? K_LO[LZC_WIDTH:0] : k_full[LZC_WIDTH:0];
      // -k-1 == ~k, so negative k shifts by its complement
      shamt  = k_c[LZC_WIDTH] ? ~k_c[LZC_WIDTH-1:0] : k_c[LZC_WIDTH-1:0];
      // Seed "10.." for k>=0 (sign-extends into ones), "01.." for k<0 (shifts in zeros)
      x      = {~k_c[LZC_WIDTH], k_c[LZC_WIDTH], (SW-2)'(0)}
             | (SW'(exp_u & EMASK) << (SW-2-es))
             | (SW'(frac_i) << (SW-2-es-FRAC_WIDTH));
      sh       = $unsigned($signed(x) >>> shamt);
      d_body   = sh[SW-1 -: BW];
      d_guard  = sh[SW-1-BW];
      d_sticky = (|sh[SW-2-BW:0]) | sticky_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid  <= 1'b0;
         s1_body   <= '0;
         s1_guard  <= 1'b0;
         s1_sticky <= 1'b0;
         s1_sign   <= 1'b0;
         s1_zero   <= 1'b0;
         s1_nar    <= 1'b0;
         s1_maxpos <= 1'b0;
         s1_minpos <= 1'b0;
      end else if (in_ready_o) begin
         s1_valid <= in_valid_i;
         if (in_valid_i) begin
            s1_body   <= d_body;
            s1_guard  <= d_guard;
            s1_sticky <= d_sticky;
            s1_sign   <= sign_i;
            s1_zero   <= zero_i;
            s1_nar    <= nar_i;
            s1_maxpos <= k_max;
            s1_minpos <= k_min;
         end
      end
   end

   // ---------------- stage 2: round, saturate, sign ----------------
   logic          inc;
   logic [BW:0]   sum;
   logic [BW-1:0] body_r;
   logic [n-1:0]  mag, res;

   always_comb begin
      inc = s1_guard & (s1_body[0] | s1_sticky);
      sum = {1'b0, s1_body} + (BW+1)'(inc);
      if (s1_maxpos || sum[BW])       body_r = '1;
      else if (s1_minpos)             body_r = BW'(1);
      else if (sum[BW-1:0] == '0)     body_r = BW'(1);
      else                            body_r = sum[BW-1:0];
      mag = {1'b0, body_r};
      if (s1_nar)       res = {1'b1, (n-1)'(0)};
      else if (s1_zero) res = '0;
      else if (s1_sign) res = -mag;
      else              res = mag;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_valid <= 1'b0;
         posit_o  <= '0;
      end else if (s1_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) posit_o <= res;
      end
   end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Bench for posit_encode_pipe (n=16, es=1): directed vectors plus randomized beats
// checked against a bit-queue posit encoding model.
module tb_posit_encode_pipe;

   logic              clk, rst;
   logic              in_valid, in_ready, out_valid, out_ready;
   logic              sign_i, zero_i, nar_i, sticky_i;
   logic signed [6:0] exp_i;
   logic [15:0]       frac_i;
   logic [15:0]       posit_o;

   int tests = 0;
   int fails = 0;

   posit_encode_pipe #(.n(16), .es(1), .FRAC_WIDTH(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .sign_i(sign_i), .zero_i(zero_i), .nar_i(nar_i),
      .exp_i(exp_i), .frac_i(frac_i), .sticky_i(sticky_i),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .posit_o(posit_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: write regime, exponent and fraction bits into a queue, cut the body.
   function automatic logic [15:0] ref_posit(input bit s, input bit z, input bit na,
                                             input int ex, input logic [15:0] fr, input bit st);
      int k, body;
      bit q[$];
      bit g, stk;
      if (na) return 16'h8000;
      if (z)  return 16'h0000;
      k = ex >>> 1;
      if (k > 14)       body = 32'h7FFF;
      else if (k < -14) body = 1;
      else begin
         if (k >= 0) begin
            for (int i = 0; i <= k; i++) q.push_back(1'b1);
            q.push_back(1'b0);
         end else begin
            for (int i = 0; i < -k; i++) q.push_back(1'b0);
            q.push_back(1'b1);
         end
         q.push_back(ex[0]);
         for (int i = 15; i >= 0; i--) q.push_back(fr[i]);
         body = 0;
         for (int i = 0; i < 15; i++) body = body * 2 + int'(q[i]);
         g = q[15];
         stk = st;
         for (int i = 16; i < q.size(); i++) stk = stk | q[i];
         if (g && ((body % 2) == 1 || stk)) body++;
         if (body > 32'h7FFF) body = 32'h7FFF;
         if (body == 0) body = 1;
      end
      return s ? 16'(-body) : 16'(body);
   endfunction

   task automatic drive(input bit s, input bit z, input bit na, input int ex,
                        input logic [15:0] fr, input bit st);
      sign_i = s; zero_i = z; nar_i = na; exp_i = 7'(ex); frac_i = fr; sticky_i = st;
      in_valid = 1'b1;
   endtask

   // One isolated beat; returns output value and cycles from accept to out_valid.
   task automatic xfer(input bit s, input bit z, input bit na, input int ex,
                       input logic [15:0] fr, input bit st,
                       output logic [15:0] res, output int lat);
      int w;
      @(negedge clk);
      out_ready = 1'b1;
      drive(s, z, na, ex, fr, st);
      #1;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); #1; w++; end
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      res = 16'hxxxx;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (out_valid) begin lat = c; res = posit_o; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(0, 0, 0, 0, 16'h0, 0); in_valid = 1'b0;
      #12;
      tests++;
      if (out_valid !== 1'b0 || posit_o !== 16'h0) begin
         fails++; $display("FAIL reset_outputs: out_valid=%b posit=%h, need 0/0000", out_valid, posit_o);
      end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_release: in_ready=%b out_valid=%b, need 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic;
      int          ex[4]   = '{0, 1, -1, 0};
      bit          sg[4]   = '{0, 0, 0, 1};
      logic [15:0] want[4] = '{16'h4000, 16'h5000, 16'h3000, 16'hC000};
      logic [15:0] r;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         xfer(sg[i], 0, 0, ex[i], 16'h0, 0, r, lat);
         tests++;
         if (lat != 2 || r !== want[i]) begin
            fails++; $display("FAIL basic[%0d]: got %h lat %0d, need %h lat 2", i, r, lat, want[i]);
         end
      end
   endtask

   task automatic test_saturation;
      int          ex[4]   = '{40, -40, 40, 29};
      bit          sg[4]   = '{0, 0, 1, 0};
      logic [15:0] fr[4]   = '{16'h0, 16'h0, 16'h0, 16'hFFFF};
      logic [15:0] want[4] = '{16'h7FFF, 16'h0001, 16'h8001, 16'h7FFF};
      logic [15:0] r;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         xfer(sg[i], 0, 0, ex[i], fr[i], 0, r, lat);
         tests++;
         if (r !== want[i]) begin
            fails++; $display("FAIL saturation[%0d]: got %h, need %h", i, r, want[i]);
         end
      end
   endtask

   task automatic test_rounding;
      logic [15:0] fr[3]   = '{16'h0008, 16'h0018, 16'h0008};
      bit          st[3]   = '{0, 0, 1};
      logic [15:0] want[3] = '{16'h4000, 16'h4002, 16'h4001};
      logic [15:0] r;
      int          lat;
      for (int i = 0; i < 3; i++) begin
         xfer(0, 0, 0, 0, fr[i], st[i], r, lat);
         tests++;
         if (r !== want[i]) begin
            fails++; $display("FAIL rounding[%0d]: got %h, need %h", i, r, want[i]);
         end
      end
   endtask

   task automatic test_specials;
      bit          z[3]    = '{1, 0, 1};
      bit          na[3]   = '{0, 1, 1};
      logic [15:0] want[3] = '{16'h0000, 16'h8000, 16'h8000};
      logic [15:0] r;
      int          lat;
      for (int i = 0; i < 3; i++) begin
         xfer(1'($urandom), z[i], na[i], $urandom_range(0, 80) - 40, 16'($urandom), 1'($urandom), r, lat);
         tests++;
         if (r !== want[i]) begin
            fails++; $display("FAIL specials[%0d]: got %h, need %h", i, r, want[i]);
         end
      end
   endtask

   task automatic test_random;
      logic [15:0] r, fr, want;
      int          lat, ex, bad;
      bit          s, z, na, st;
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         s = 1'($urandom); st = 1'($urandom);
         z = ($urandom % 16) == 0; na = ($urandom % 16) == 0;
         ex = $urandom_range(0, 80) - 40;
         fr = 16'($urandom);
         want = ref_posit(s, z, na, ex, fr, st);
         xfer(s, z, na, ex, fr, st, r, lat);
         tests++;
         if (lat != 2 || r !== want) begin
            fails++; bad++;
            if (bad < 10)
               $display("FAIL random[%0d]: s=%b z=%b nar=%b exp=%0d frac=%h st=%b got %h lat %0d, need %h",
                        i, s, z, na, ex, fr, st, r, lat, want);
         end
      end
   endtask

   task automatic test_backpressure;
      int          ex[3];
      logic [15:0] fr[3], want[3], got[3];
      int          idx, cnt;
      bit          rdy;
      for (int i = 0; i < 3; i++) begin
         ex[i] = $urandom_range(0, 60) - 30; fr[i] = 16'($urandom);
         want[i] = ref_posit(0, 0, 0, ex[i], fr[i], 0);
      end
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         if (idx < 3) drive(0, 0, 0, ex[idx], fr[idx], 0);
         #1 rdy = in_ready;
         @(posedge clk);
         if (in_valid && rdy) idx++;
      end
      @(negedge clk);
      tests++;
      if (idx != 2 || in_ready !== 1'b0) begin
         fails++; $display("FAIL bp_accept: accepted %0d in_ready=%b, need 2/0", idx, in_ready);
      end
      for (int c = 0; c < 3; c++) begin
         tests++;
         if (out_valid !== 1'b1 || posit_o !== want[0]) begin
            fails++; $display("FAIL bp_hold[%0d]: out_valid=%b posit=%h, need 1/%h", c, out_valid, posit_o, want[0]);
         end
         @(negedge clk);
      end
      cnt = 0;
      for (int c = 0; c < 20 && cnt < 3; c++) begin
         if (c > 0) @(negedge clk);
         if (out_valid) begin got[cnt] = posit_o; cnt++; end
         out_ready = 1'b1;
         if (idx < 3) drive(0, 0, 0, ex[idx], fr[idx], 0); else in_valid = 1'b0;
         #1 rdy = in_ready;
         @(posedge clk);
         if (in_valid && rdy) idx++;
      end
      #1 in_valid = 1'b0;
      tests++;
      if (cnt != 3) begin
         fails++; $display("FAIL bp_drain_count: got %0d outputs, need 3", cnt);
      end
      for (int i = 0; i < cnt; i++) begin
         tests++;
         if (got[i] !== want[i]) begin
            fails++; $display("FAIL bp_order[%0d]: got %h, need %h", i, got[i], want[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int          ex[8];
      logic [15:0] fr[8], want[8], got[8];
      bit          sg[8];
      int          cnt, first, last;
      for (int i = 0; i < 8; i++) begin
         ex[i] = $urandom_range(0, 70) - 35; fr[i] = 16'($urandom); sg[i] = 1'($urandom);
         want[i] = ref_posit(sg[i], 0, 0, ex[i], fr[i], 0);
      end
      cnt = 0; first = -1; last = -1;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid && cnt < 8) begin
            got[cnt] = posit_o; cnt++;
            if (first < 0) first = c;
            last = c;
         end
         if (c < 8) drive(sg[c], 0, 0, ex[c], fr[c], 0); else in_valid = 1'b0;
      end
      tests++;
      if (cnt != 8 || last - first != 7 || first != 2) begin
         fails++; $display("FAIL b2b_rate: %0d outputs over cycles %0d..%0d, need 8 over 2..9", cnt, first, last);
      end
      for (int i = 0; i < cnt; i++) begin
         tests++;
         if (got[i] !== want[i]) begin
            fails++; $display("FAIL b2b_value[%0d]: got %h, need %h", i, got[i], want[i]);
         end
      end
   endtask

   task automatic test_async_reset;
      int stale;
      out_ready = 1'b1;
      @(negedge clk) drive(0, 0, 0, 2, 16'h1234, 0);
      @(posedge clk);
      @(negedge clk) drive(1, 0, 0, -3, 16'h4321, 0);
      @(posedge clk);
      #2 in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1) begin
         fails++; $display("FAIL arst_inflight: out_valid=%b, need 1", out_valid);
      end
      #1 rst = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || posit_o !== 16'h0) begin
         fails++; $display("FAIL arst_immediate: out_valid=%b posit=%h, need 0/0000", out_valid, posit_o);
      end
      @(negedge clk) rst = 1'b0;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      tests++;
      if (stale != 0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL arst_stale: %0d stale outputs in_ready=%b, need 0/1", stale, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_rounding();
      test_specials();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/posit_encode_pipe.md
Name: posit_encode_pipe

Overview:
- Packs a normalized result (sign, combined signed scale exponent, fraction, sticky) back into an n-bit posit word.
- The scale exponent has the same format that the regime/exponent combiner produces: (k << es) | exp.
- Sits at the back end of the dot-product datapath, after normalization.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
n, 16, posit word width
es, 1, posit exponent field width
FRAC_WIDTH, 16, width of incoming fraction bits (hidden one excluded, MSB-aligned)
LZC_WIDTH, clog2(n-1), derived, do not override
EXP_WIDTH, LZC_WIDTH+1+es, derived, do not override

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
in_valid_i  in  1  input beat valid
in_ready_o  out  1  block can accept a beat
sign_i  in  1  result sign
zero_i  in  1  result is exactly zero
nar_i  in  1  result is NaR (wins over zero_i)
exp_i  in  EXP_WIDTH+1  signed scale exponent
frac_i  in  FRAC_WIDTH  fraction bits after the hidden one
sticky_i  in  1  OR of all discarded bits below frac_i
out_valid_o  out  1  posit_o valid
out_ready_i  in  1  downstream accepts
posit_o  out  n  encoded posit

Behaviour:
- Reset (asynchronous, active-high): both stage valids clear, out_valid_o=0, posit_o=0.
  - in_ready_o=1 once rst_i deasserts.
  - Reset mid-operation discards all in-flight beats.
- Handshake:
  - A beat transfers when valid and ready are both high on a rising edge.
  - in_ready_o = !s1_valid | s1_adv, where s1_adv = !s2_valid | out_ready_i.
  - in_ready_o must not depend on in_valid_i.
  - While out_valid_o=1 and out_ready_i=0, posit_o stays stable.
- Latency: 2 cycles from accept to out_valid_o. Full throughput is 1 beat/cycle. Order is preserved and no beat is dropped.
- Stage 1 (decode and regime build):
  - k = exp_i >>> es (arithmetic shift); e = exp_i[es-1:0]; e=0 when es=0.
  - k > n-2: flag maxpos.
  - k < -(n-2): flag minpos.
  - Otherwise build regime:
    - k>=0: k+1 ones followed by a 0.
    - k<0: -k zeros followed by a 1.
  - Concatenate {regime, e, frac_i}, then left-align it into the n-1 body bits plus guard bit.
  - Collect all bits below the guard bit, together with sticky_i, into a sticky flag.
  - Register the body, guard, sticky, sign and the special flags.
- Stage 2 (round and sign):
  - Round to nearest, ties to even: increment when guard & (lsb | sticky).
  - A rounded body of all zeros becomes minpos (1). Rounding never reaches 0 or NaR.
  - maxpos body is all ones; an increment that would carry out saturates to maxpos.
  - sign=1: posit_o = two's complement of {0, body}.
  - nar_i: posit_o = 1 followed by n-1 zeros.
  - zero_i (and not nar_i): posit_o = 0.
  - Special cases ignore exp_i, frac_i and sticky_i.
  - Saturation is symmetric: negative overflow gives -maxpos, negative underflow gives -minpos.
- Width rules:
  - Internal shift vector is at least n+FRAC_WIDTH+es+1 bits, so no bits are lost before the sticky OR.
  - k is stored as a signed LZC_WIDTH+1 value after clamping.

Test Plan:
- Basic encodes (n=16, es=1), each with sign=0, frac_i=0, sticky=0:
  - exp_i=0 -> 0x4000
  - exp_i=1 -> 0x5000
  - exp_i=-1 -> 0x3000
  - exp_i=0 with sign=1 -> 0xC000
  - Each appears 2 cycles after accept.
- Saturation:
  - exp_i=40 -> 0x7FFF
  - exp_i=-40 -> 0x0001
  - exp_i=40 with sign=1 -> 0x8001
  - exp_i=29 with frac_i=0xFFFF -> 0x7FFF, no wrap to NaR
- Rounding, with exp_i=0:
  - frac_i=0x0008, sticky=0 -> 0x4000 (tie, even lsb)
  - frac_i=0x0018 -> 0x4002
  - frac_i=0x0008, sticky=1 -> 0x4001
- Specials:
  - zero_i=1 -> 0x0000
  - nar_i=1 -> 0x8000
  - zero_i=1 and nar_i=1 together -> 0x8000
- Backpressure and throughput:
  - Hold out_ready_i=0 and offer 3 beats: exactly 2 accepted, in_ready_o=0 afterward, posit_o held.
  - Release out_ready_i: all 3 outputs emerge in order.
  - Then a back-to-back stream of 8 beats: one output per cycle.
- Asynchronous reset: assert rst_i between clock edges with 2 beats in flight -> out_valid_o drops immediately, posit_o=0, and no stale beat appears after release.
